// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM states, bubble word, and the
// instruction field bit positions that the control decoder also slices.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 26;
    localparam int BIT21    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int SA_HI    = 10;
    localparam int SA_LO    = 6;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    function automatic logic [31:0] pc_plus4(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/grant/response bus between fetch and memory.
interface instr_fetch_unit_if;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemGnt;
    logic        IMemRValid;
    logic [31:0] IMemRData;

    modport master (output IMemReq, output IMemAddr,
                    input  IMemGnt, input IMemRValid, input IMemRData);
    modport slave  (input  IMemReq, input IMemAddr,
                    output IMemGnt, output IMemRValid, output IMemRData);
endinterface

// File: rtl/instr_fetch_unit_chk.sv
// Protocol checker: a memory response is only legal while a fetch is pending.
module instr_fetch_unit_chk
    import instr_fetch_unit_pkg::*;
(
    input logic         clk,
    input logic         rst,
    input fetch_state_e state,
    input logic         rvalid
);

    // A response in REQ or HOLD has no matching request and is dropped
    rsp_only_when_pending: assert property (
        @(posedge clk) disable iff (rst)
        !(rvalid && ((state == REQ) || (state == HOLD)))
    );

endmodule

// File: rtl/instr_fetch_unit_ifid_reg.sv
// IF/ID pipeline register with flush > stall > load > bubble priority,
// plus the decoder field slices taken straight from the held instruction.
module instr_fetch_unit_ifid_reg
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = instr_fetch_unit_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc4,
    output logic [31:0] instruction,
    output logic [31:0] pc_plus4_out,
    output logic        id_valid,
    output logic [5:0]  opcode,
    output logic        bit21,
    output logic [4:0]  bit20_16,
    output logic [4:0]  bit10_6,
    output logic [5:0]  funct
);

    logic [31:0] instr_r;
    logic [31:0] pc4_r;
    logic        valid_r;

    // IF/ID state update; PCPlus4 is left alone on flush and bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_r <= NOP_WORD;
            pc4_r   <= 32'h0000_0000;
            valid_r <= 1'b0;
        end else if (flush) begin
            instr_r <= NOP_WORD;
            pc4_r   <= pc4_r;
            valid_r <= 1'b0;
        end else if (stall) begin
            instr_r <= instr_r;
            pc4_r   <= pc4_r;
            valid_r <= valid_r;
        end else if (load) begin
            instr_r <= load_instr;
            pc4_r   <= load_pc4;
            valid_r <= 1'b1;
        end else begin
            instr_r <= NOP_WORD;
            pc4_r   <= pc4_r;
            valid_r <= 1'b0;
        end
    end

    assign instruction  = instr_r;
    assign pc_plus4_out = pc4_r;
    assign id_valid     = valid_r;
    assign opcode       = instr_r[OPC_HI:OPC_LO];
    assign bit21        = instr_r[BIT21];
    assign bit20_16     = instr_r[RT_HI:RT_LO];
    assign bit10_6      = instr_r[SA_HI:SA_LO];
    assign funct        = instr_r[FUNCT_HI:FUNCT_LO];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, runs the single-outstanding memory handshake,
// buffers a response that lands during a stall, and feeds the IF/ID register.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = instr_fetch_unit_pkg::NOP_WORD
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       Stall,
    input  logic                       Redirect,
    input  logic [31:0]                RedirectPC,
    instr_fetch_unit_if.master         imem,
    output logic [31:0]                Instruction,
    output logic [31:0]                PCPlus4,
    output logic                       IDValid,
    output logic [5:0]                 Opcode,
    output logic                       Bit21,
    output logic [4:0]                 Bit20_16,
    output logic [4:0]                 Bit10_6,
    output logic [5:0]                 funct
);

    fetch_state_e state_r, state_n_s;
    logic [31:0]  pc_r, pc_n_s;
    logic [31:0]  req_pc_r, req_pc_n_s;
    logic [31:0]  buf_r, buf_n_s;
    logic         load_s;
    logic [31:0]  load_instr_s;
    logic [31:0]  next_pc4_s;

    // Fetch state, PC, in-flight address and stall buffer
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r  <= REQ;
            pc_r     <= word_align(RESET_PC);
            req_pc_r <= 32'h0000_0000;
            buf_r    <= NOP_WORD;
        end else begin
            state_r  <= state_n_s;
            pc_r     <= pc_n_s;
            req_pc_r <= req_pc_n_s;
            buf_r    <= buf_n_s;
        end
    end

    // Next-state: redirect overrides stall; an in-flight fetch is drained
    always_comb begin
        state_n_s    = state_r;
        pc_n_s       = pc_r;
        req_pc_n_s   = req_pc_r;
        buf_n_s      = buf_r;
        load_s       = 1'b0;
        load_instr_s = buf_r;
        next_pc4_s   = pc_plus4(req_pc_r);
        if (Redirect) begin
            pc_n_s = word_align(RedirectPC);
            case (state_r)
                REQ:     if (imem.IMemGnt)    state_n_s = DRAIN; else state_n_s = REQ;
                WAIT:    if (imem.IMemRValid) state_n_s = REQ;   else state_n_s = DRAIN;
                HOLD:    state_n_s = REQ;
                DRAIN:   if (imem.IMemRValid) state_n_s = REQ;   else state_n_s = DRAIN;
                default: state_n_s = REQ;
            endcase
        end else begin
            case (state_r)
                REQ: begin
                    if (imem.IMemGnt) begin
                        req_pc_n_s = pc_r;
                        state_n_s  = WAIT;
                    end else begin
                        state_n_s  = REQ;
                    end
                end
                WAIT: begin
                    if (imem.IMemRValid && !Stall) begin
                        load_s       = 1'b1;
                        load_instr_s = imem.IMemRData;
                        pc_n_s       = next_pc4_s;
                        state_n_s    = REQ;
                    end else if (imem.IMemRValid) begin
                        buf_n_s      = imem.IMemRData;
                        state_n_s    = HOLD;
                    end else begin
                        state_n_s    = WAIT;
                    end
                end
                HOLD: begin
                    if (!Stall) begin
                        load_s    = 1'b1;
                        pc_n_s    = next_pc4_s;
                        state_n_s = REQ;
                    end else begin
                        state_n_s = HOLD;
                    end
                end
                DRAIN:   if (imem.IMemRValid) state_n_s = REQ; else state_n_s = DRAIN;
                default: state_n_s = REQ;
            endcase
        end
    end

    assign imem.IMemReq  = (state_r == REQ);
    assign imem.IMemAddr = word_align(pc_r);

    instr_fetch_unit_ifid_reg #(.NOP_WORD(NOP_WORD)) u_ifid (
        .clk          (Clk),
        .rst          (Reset),
        .load         (load_s),
        .stall        (Stall),
        .flush        (Redirect),
        .load_instr   (load_instr_s),
        .load_pc4     (next_pc4_s),
        .instruction  (Instruction),
        .pc_plus4_out (PCPlus4),
        .id_valid     (IDValid),
        .opcode       (Opcode),
        .bit21        (Bit21),
        .bit20_16     (Bit20_16),
        .bit10_6      (Bit10_6),
        .funct        (funct)
    );

    instr_fetch_unit_chk u_chk (
        .clk    (Clk),
        .rst    (Reset),
        .state  (state_r),
        .rvalid (imem.IMemRValid)
    );

endmodule
